fpga_link_tx: RTL and testbench
===============================

# fpga_link_tx

Transmit side of an inter-FPGA router link. Accepts the 17-bit flit a ring router drives toward a neighbouring FPGA, buffers it in a small FIFO, and serialises the 16-bit payload onto a narrow lane to cut board pin count. It sits directly downstream of a router output port (`out_r1R` / `out_r2R` / `out_r1L` / `out_r2L`) in place of the current full-width `data_TO_fpgaN` assignment.

## Interface
- `LANE_W`, 4, lane width in bits; legal values are 1, 2, 4, 8 and 16. Beats per frame: `BEATS = 16/LANE_W`.
- `FIFO_DEPTH`, 4, flit FIFO depth; a power of two, at least 2.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flit_in` input 17: router output flit. Bit 16 is valid; bits [15:0] are the payload.
- `lane_stop` input 1: stop request from the far end. While high, no new frame starts.
- `lane_data` output LANE_W: serial payload beat.
- `lane_frame` output 1: high on every beat of a frame.
- `lane_sof` output 1: high on beat 0 of each frame only.
- `fifo_level` output clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `ovf_cnt` output 8: count of dropped flits. Saturates at 255.

## Operation
- **Push:** in any cycle with `flit_in[16]`=1, write `flit_in[15:0]` to the FIFO if there is room.
- **Overflow:** if the FIFO is full and there is no pop in the same cycle, drop the flit and increment `ovf_cnt` (saturating at 255).
- **Push and pop together on a full FIFO:** the push is accepted and nothing is dropped.
- **FSM states:**
  - IDLE, with `beat_cnt`=0.
  - SEND, with `beat_cnt` running 0..BEATS-1.
- **IDLE → SEND:** when the FIFO is non-empty and `lane_stop`=0, pop the head into the shift register and enter SEND.
- **SEND:**
  - Each cycle drives one beat, MSB first: beat k = `payload[15-k*LANE_W -: LANE_W]`.
  - `lane_sof`=1 on beat 0.
- **Last beat:**
  - If the FIFO is non-empty and `lane_stop`=0, pop the next flit so that its beat 0 follows with no gap.
  - Otherwise return to IDLE.
- **`lane_stop` timing:** only sampled at frame boundaries (in IDLE, and on the last beat). A frame already in progress always completes.
- **LANE_W=16:** BEATS=1, so every frame is a single beat with `lane_sof`=`lane_frame`=1.
- **Between frames:** `lane_data` holds 0 whenever `lane_frame`=0.
- **Registered outputs:** `lane_data`, `lane_frame` and `lane_sof` are all registered; nothing combinational runs from an input to them.
- **`fifo_level`:** reflects the post-edge occupancy; simultaneous push and pop leaves it unchanged.

## Timing
- **Reset:** all outputs are 0 and the FIFO is empty.
  - `lane_frame`, `lane_sof`, `lane_data`, `fifo_level` and `ovf_cnt` clear asynchronously as soon as `rst` asserts.
  - Reset mid-frame truncates the frame immediately; the far end discards partial frames.
- **Latency:** a flit presented at edge t into an empty FIFO in IDLE:
  - is written at edge t;
  - is popped at edge t+1;
  - has beat 0 on the lane after edge t+2, i.e. 2 cycles latency.
- **Frame length:** exactly BEATS cycles.
- **Sustained throughput:** one flit per BEATS cycles, because back-to-back frames have zero idle cycles. Input flits arriving faster than this accumulate in the FIFO.
- **`lane_stop` latency:** asserting it stops new frames from the next boundary onward. Deasserting it in IDLE starts a frame on the following edge (beat 0 one cycle later).
- **FIFO pointers:** wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

## Test plan
- **Single flit:** after reset, with LANE_W=4, apply one flit 0x1A5C3 for one cycle. Required: beats A,5,C,3 on cycles t+2..t+5, `lane_sof` only on the A beat, `lane_frame` high for exactly 4 cycles, then `lane_data`=0.
- **Back-to-back:** push 0x11234 and 0x1ABCD on consecutive cycles. Required: beats 1,2,3,4,A,B,C,D contiguous, `lane_sof` on the 1 and A beats, no gap; `fifo_level` peaks at 1.
- **Overflow:** hold `lane_stop`=1 and push 6 flits with FIFO_DEPTH=4. Required: `fifo_level`=4 and `ovf_cnt`=2. Release `lane_stop`: the first 4 payloads are sent in order.
- **Stop mid-frame:** assert `lane_stop` during beat 1 of a frame with 2 flits queued. Required: the current frame finishes all 4 beats, then `lane_frame`=0 until release, then the next frame's beat 0 one cycle after release.
- **Saturation:** keep `lane_stop`=1 with a full FIFO and push 300 flits. Required: `ovf_cnt` stays at 255.
- **Reset mid-frame:** assert `rst` on beat 2. Required: all outputs are 0 immediately and `fifo_level`=0. After release, a new flit 0x1FFFF produces F,F,F,F with correct `lane_sof`.

Source files
------------

// File: rtl/fpga_link_tx.sv
// fpga_link_tx: transmit side of an inter-FPGA router link.
// Router flits are queued in a small FIFO. Each 16-bit payload is then sent
// over a LANE_W-bit lane as BEATS = 16/LANE_W beats, most significant beat first.
// Frames follow each other with no idle cycle while flits are waiting and the
// far end is not asserting lane_stop.
module fpga_link_tx #(
    parameter int LANE_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [16:0]                   flit_in,
    input  logic                          lane_stop,
    output logic [LANE_W-1:0]             lane_data,
    output logic                          lane_frame,
    output logic                          lane_sof,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    ovf_cnt
);

    localparam int BEATS = 16 / LANE_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_reg, state_next;
    logic [BCW-1:0]  beat_cnt_reg;
    logic [15:0]     shift_reg;

    // Flit storage. The pointers carry one extra bit so that full and empty
    // can be told apart when the index bits are equal.
    logic [15:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0]   wr_idx, rd_idx;
    logic            fifo_empty, fifo_full;
    logic            flit_valid;
    logic            push_ok, drop;
    logic            pop;
    logic            last_beat;

    assign wr_idx     = wr_ptr_reg[AW-1:0];
    assign rd_idx     = rd_ptr_reg[AW-1:0];
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign fifo_level = wr_ptr_reg - rd_ptr_reg;

    assign flit_valid = flit_in[16];
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign push_ok    = flit_valid && (!fifo_full || pop);
    assign drop       = flit_valid && fifo_full && !pop;

    // Next-state logic. lane_stop only matters at frame boundaries: in IDLE and
    // on the last beat. A frame that has started always runs to completion.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        last_beat  = (state_reg == SEND) && (beat_cnt_reg == LAST_BEAT);
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !lane_stop) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (last_beat) begin
                    if (!fifo_empty && !lane_stop) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO payload array. It holds no control state, so it is not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= flit_in[15:0];
        end
    end

    // FIFO pointers and the saturating count of dropped flits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (drop && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

    // FSM state, beat counter and payload shift register. The popped head is
    // loaded here, and beat 0 reaches the lane one cycle after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            shift_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                shift_reg    <= mem[rd_idx];
                beat_cnt_reg <= '0;
            end else if (state_reg == SEND) begin
                shift_reg    <= shift_reg << LANE_W;
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + BCW'(1);
            end
        end
    end

    // Registered lane outputs. They are driven only from internal state, and
    // lane_data is forced to zero outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_data  <= '0;
            lane_frame <= 1'b0;
            lane_sof   <= 1'b0;
        end else if (state_reg == SEND) begin
            lane_data  <= shift_reg[15 -: LANE_W];
            lane_frame <= 1'b1;
            lane_sof   <= (beat_cnt_reg == '0);
        end else begin
            lane_data  <= '0;
            lane_frame <= 1'b0;
            lane_sof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpga_link_tx.sv
// Directed testbench for fpga_link_tx with LANE_W=4 and FIFO_DEPTH=4.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, so each sample shows the state just after the edge.
module tb_fpga_link_tx;

    localparam int LANE_W     = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] flit_in = '0;
    logic        lane_stop = 1'b0;
    logic [3:0]  lane_data;
    logic        lane_frame;
    logic        lane_sof;
    logic [2:0]  fifo_level;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int errors = 0;

    fpga_link_tx #(
        .LANE_W    (LANE_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flit_in   (flit_in),
        .lane_stop (lane_stop),
        .lane_data (lane_data),
        .lane_frame(lane_frame),
        .lane_sof  (lane_sof),
        .fifo_level(fifo_level),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flit_in = '0;
        lane_stop = 1'b0;
        tick();
        checks++; if (lane_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", lane_data); end
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", lane_frame); end
        checks++; if (lane_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", lane_sof); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", ovf_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL idle_frame: got %b expected 0", lane_frame); end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        logic [3:0] exp_beats [4];
        exp_beats = '{4'hA, 4'h5, 4'hC, 4'h3};
        flit_in = 17'h1A5C3;
        tick();                     // edge t: flit written
        flit_in = '0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_write: got %0d expected 1", fifo_level); end
        tick();                     // edge t+1: flit popped, lane still idle
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL single_latency_frame: got %b expected 0", lane_frame); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_pop: got %0d expected 0", fifo_level); end
        for (int k = 0; k < 4; k++) begin
            tick();                 // edges t+2 .. t+5
            checks++; if (lane_data !== exp_beats[k]) begin errors++; $display("FAIL single_data beat %0d: got %h expected %h", k, lane_data, exp_beats[k]); end
            checks++; if (lane_frame !== 1'b1) begin errors++; $display("FAIL single_frame beat %0d: got %b expected 1", k, lane_frame); end
            checks++; if (lane_sof !== (k == 0)) begin errors++; $display("FAIL single_sof beat %0d: got %b expected %b", k, lane_sof, (k == 0)); end
        end
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL single_end_frame: got %b expected 0", lane_frame); end
        checks++; if (lane_data !== 4'h0) begin errors++; $display("FAIL single_end_data: got %h expected 0", lane_data); end
        // Flits without the valid bit set must not be queued.
        flit_in = 17'h0BEEF;
        tick();
        tick();
        flit_in = '0;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL invalid_flit_level: got %0d expected 0", fifo_level); end
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL invalid_flit_frame: got %b expected 0", lane_frame); end
        $display("test_single done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_data [9];
        logic       exp_sof  [9];
        logic       exp_frm  [9];
        logic [2:0] max_level;
        exp_data = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0};
        exp_sof  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_frm  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        flit_in = 17'h11234;
        tick();
        max_level = fifo_level;
        flit_in = 17'h1ABCD;
        tick();
        if (fifo_level > max_level) max_level = fifo_level;
        flit_in = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (fifo_level > max_level) max_level = fifo_level;
            checks++; if (lane_data !== exp_data[i]) begin errors++; $display("FAIL b2b_data cycle %0d: got %h expected %h", i, lane_data, exp_data[i]); end
            checks++; if (lane_sof !== exp_sof[i]) begin errors++; $display("FAIL b2b_sof cycle %0d: got %b expected %b", i, lane_sof, exp_sof[i]); end
            checks++; if (lane_frame !== exp_frm[i]) begin errors++; $display("FAIL b2b_frame cycle %0d: got %b expected %b", i, lane_frame, exp_frm[i]); end
        end
        checks++; if (max_level !== 3'd1) begin errors++; $display("FAIL b2b_peak_level: got %0d expected 1", max_level); end
        $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_overflow();
        logic [15:0] pay [6];
        logic [15:0] p;
        logic [3:0]  exp_b;
        pay = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h5A5A, 16'hA5A5};
        lane_stop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            flit_in = {1'b1, pay[i]};
            tick();
        end
        flit_in = '0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
        checks++; if (ovf_cnt !== 8'd2) begin errors++; $display("FAIL ovf_count: got %0d expected 2", ovf_cnt); end
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL ovf_stopped_frame: got %b expected 0", lane_frame); end
        lane_stop = 1'b0;
        tick();                     // first pop
        for (int f = 0; f < 4; f++) begin
            p = pay[f];
            for (int k = 0; k < 4; k++) begin
                tick();
                exp_b = p[15 - 4*k -: 4];
                checks++; if (lane_data !== exp_b) begin errors++; $display("FAIL ovf_drain_data flit %0d beat %0d: got %h expected %h", f, k, lane_data, exp_b); end
                checks++; if (lane_sof !== (k == 0)) begin errors++; $display("FAIL ovf_drain_sof flit %0d beat %0d: got %b expected %b", f, k, lane_sof, (k == 0)); end
                checks++; if (lane_frame !== 1'b1) begin errors++; $display("FAIL ovf_drain_frame flit %0d beat %0d: got %b expected 1", f, k, lane_frame); end
            end
        end
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL ovf_drain_end: got %b expected 0", lane_frame); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drain_level: got %0d expected 0", fifo_level); end
        $display("test_overflow done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_stop_mid_frame();
        logic [15:0] pay [3];
        logic [15:0] p;
        logic [3:0]  exp_b;
        pay = '{16'h1357, 16'h2468, 16'h9ACE};
        lane_stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flit_in = {1'b1, pay[i]};
            tick();
        end
        flit_in = '0;
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL stop_queued_level: got %0d expected 3", fifo_level); end
        lane_stop = 1'b0;
        tick();                     // pop of the first flit
        p = pay[0];
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 1) lane_stop = 1'b1;   // asserted during beat 1
            exp_b = p[15 - 4*k -: 4];
            checks++; if (lane_data !== exp_b) begin errors++; $display("FAIL stop_cur_data beat %0d: got %h expected %h", k, lane_data, exp_b); end
            checks++; if (lane_frame !== 1'b1) begin errors++; $display("FAIL stop_cur_frame beat %0d: got %b expected 1", k, lane_frame); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL stop_hold_frame cycle %0d: got %b expected 0", i, lane_frame); end
            checks++; if (lane_data !== 4'h0) begin errors++; $display("FAIL stop_hold_data cycle %0d: got %h expected 0", i, lane_data); end
        end
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL stop_hold_level: got %0d expected 2", fifo_level); end
        lane_stop = 1'b0;
        tick();                     // pop edge; beat 0 follows one cycle later
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL stop_release_frame: got %b expected 0", lane_frame); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL stop_release_level: got %0d expected 1", fifo_level); end
        for (int f = 1; f < 3; f++) begin
            p = pay[f];
            for (int k = 0; k < 4; k++) begin
                tick();
                exp_b = p[15 - 4*k -: 4];
                checks++; if (lane_data !== exp_b) begin errors++; $display("FAIL stop_next_data flit %0d beat %0d: got %h expected %h", f, k, lane_data, exp_b); end
                checks++; if (lane_sof !== (k == 0)) begin errors++; $display("FAIL stop_next_sof flit %0d beat %0d: got %b expected %b", f, k, lane_sof, (k == 0)); end
                checks++; if (lane_frame !== 1'b1) begin errors++; $display("FAIL stop_next_frame flit %0d beat %0d: got %b expected 1", f, k, lane_frame); end
            end
        end
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL stop_end_frame: got %b expected 0", lane_frame); end
        $display("test_stop_mid_frame done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_saturation();
        logic [15:0] p;
        // ovf_cnt enters at 2; pushes 1..4 fill the FIFO, and push n>4 drops.
        lane_stop = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            p = 16'h7000 + 16'(n);
            flit_in = {1'b1, p};
            tick();
            if (n == 256) begin
                checks++; if (ovf_cnt !== 8'd254) begin errors++; $display("FAIL sat_before: got %0d expected 254", ovf_cnt); end
            end
            if (n == 257) begin
                checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d expected 255", ovf_cnt); end
            end
        end
        flit_in = '0;
        checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", ovf_cnt); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL sat_level: got %0d expected 4", fifo_level); end
        $display("test_saturation done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] exp_beats [4];
        exp_beats = '{4'hF, 4'hF, 4'hF, 4'hF};
        lane_stop = 1'b0;
        tick();                     // pop
        tick();                     // beat 0
        tick();                     // beat 1
        tick();                     // beat 2
        checks++; if (lane_frame !== 1'b1) begin errors++; $display("FAIL rmf_in_frame: got %b expected 1", lane_frame); end
        #2;
        rst = 1'b1;                 // mid-cycle, away from any clock edge
        #1;
        checks++; if (lane_data !== 4'h0) begin errors++; $display("FAIL rmf_data: got %h expected 0", lane_data); end
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL rmf_frame: got %b expected 0", lane_frame); end
        checks++; if (lane_sof !== 1'b0) begin errors++; $display("FAIL rmf_sof: got %b expected 0", lane_sof); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rmf_level: got %0d expected 0", fifo_level); end
        checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL rmf_ovf: got %0d expected 0", ovf_cnt); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL rmf_after_frame: got %b expected 0", lane_frame); end
        flit_in = 17'h1FFFF;
        tick();
        flit_in = '0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL rmf_new_level: got %0d expected 1", fifo_level); end
        tick();                     // pop
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (lane_data !== exp_beats[k]) begin errors++; $display("FAIL rmf_new_data beat %0d: got %h expected %h", k, lane_data, exp_beats[k]); end
            checks++; if (lane_sof !== (k == 0)) begin errors++; $display("FAIL rmf_new_sof beat %0d: got %b expected %b", k, lane_sof, (k == 0)); end
            checks++; if (lane_frame !== 1'b1) begin errors++; $display("FAIL rmf_new_frame beat %0d: got %b expected 1", k, lane_frame); end
        end
        tick();
        checks++; if (lane_frame !== 1'b0) begin errors++; $display("FAIL rmf_end_frame: got %b expected 0", lane_frame); end
        checks++; if (lane_data !== 4'h0) begin errors++; $display("FAIL rmf_end_data: got %h expected 0", lane_data); end
        $display("test_reset_mid_frame done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_stop_mid_frame();
        test_saturation();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
